fp_sum_sequencer: RTL



---
 rtl/fp_sum_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/fp_sum_sequencer.sv
// Initiator side of the FP adder strobe/acknowledge protocol: folds a stream of
// IEEE single operands into a running sum, one adder transaction per element.
`timescale 1ns/1ps
module fp_sum_sequencer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] count,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      add_a,
  output logic             add_a_stb,
  input  logic             add_a_ack,
  output logic [31:0]      add_b,
  output logic             add_b_stb,
  input  logic             add_b_ack,
  input  logic [31:0]      add_z,
  input  logic             add_z_stb,
  output logic             add_z_ack,
  output logic [31:0]      sum,
  output logic             done,
  output logic             busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] SEND_A = 3'd2;
  localparam logic [2:0] SEND_B = 3'd3;
  localparam logic [2:0] WAIT_Z = 3'd4;
  localparam logic [2:0] FINISH = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [31:0]      acc;
  logic [LEN_W-1:0] remaining;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (count == '0) ? FINISH : FETCH;
      FETCH:   if (in_valid && in_ready) state_nxt = SEND_A;
      SEND_A:  if (add_a_stb && add_a_ack) state_nxt = SEND_B;
      SEND_B:  if (add_b_stb && add_b_ack) state_nxt = WAIT_Z;
      WAIT_Z:  if (add_z_stb && add_z_ack)
                 state_nxt = (remaining == LEN_W'(1)) ? FINISH : FETCH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready and busy are registered from the next state so they track state exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      add_a_stb <= 1'b0;
      add_b_stb <= 1'b0;
      add_z_ack <= 1'b0;
      add_a     <= 32'h0;
      add_b     <= 32'h0;
      sum       <= 32'h0;
      acc       <= 32'h0;
      remaining <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == FETCH);
      busy     <= (state_nxt != IDLE);
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= count;
            acc       <= 32'h0;
          end
        end
        FETCH: begin
          if (in_valid && in_ready) begin
            add_b     <= in_data;
            add_a     <= acc;
            add_a_stb <= 1'b1;
          end
        end
        SEND_A: begin
          if (add_a_stb && add_a_ack) begin
            add_a_stb <= 1'b0;
            add_b_stb <= 1'b1;
          end
        end
        SEND_B: begin
          if (add_b_stb && add_b_ack) begin
            add_b_stb <= 1'b0;
            add_z_ack <= 1'b1;
          end
        end
        WAIT_Z: begin
          // WAIT_Z is only entered with remaining >= 1, so this never wraps
          if (add_z_stb && add_z_ack) begin
            acc       <= add_z;
            add_z_ack <= 1'b0;
            remaining <= remaining - LEN_W'(1);
          end
        end
        FINISH: begin
          sum  <= acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
